fetch_decode: RTL and testbench

- Instruction fetch/decode front end for the 15-bit CPU.
- Drives the program address P_COUNT into the registered program ROM and latches the returned 15-bit word into an instruction register (IR).
- Splits the IR into opcode and fields, and resolves control flow (jmp, je, hlt) locally.
- Issues all other instructions to the execute unit over a valid/ready handshake.

---
 rtl/cpu15_pkg.sv | 53 +++++
 rtl/fetch_decode_if.sv | 31 +++
 rtl/insn_field_split.sv | 37 +++
 rtl/fetch_decode.sv | 112 +++++++++++
 tb/tb_fetch_decode.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/cpu15_pkg.sv
// ---------------------------------------------------------------------------
// cpu15_pkg
// Shared definitions for the 15-bit CPU front end:
//   - opcode encodings (IR[14:11])
//   - instruction field bit positions
//   - fetch/decode state encoding
//   - is_ctrl(): opcodes resolved inside fetch/decode (never issued)
// No ports (package).
// ---------------------------------------------------------------------------
package cpu15_pkg;

  // Opcodes
  localparam logic [3:0] OP_MOV = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_SL  = 4'h5;
  localparam logic [3:0] OP_SR  = 4'h6;
  localparam logic [3:0] OP_SRA = 4'h7;
  localparam logic [3:0] OP_LDL = 4'h8;
  localparam logic [3:0] OP_LDH = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_JE  = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_LD  = 4'hD;
  localparam logic [3:0] OP_ST  = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Field bit positions within the 15-bit instruction word
  localparam int OP_MSB  = 14;
  localparam int OP_LSB  = 11;
  localparam int RA_MSB  = 10;
  localparam int RA_LSB  = 8;
  localparam int RB_MSB  = 7;
  localparam int RB_LSB  = 5;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // Fetch/decode sequencer states
  typedef enum logic [1:0] {
    S_ADDR  = 2'd0,
    S_LATCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } fd_state_t;

  // Control-flow opcodes are resolved locally and never handed to execute.
  function automatic logic is_ctrl(input logic [3:0] op);
    return (op == OP_JE) || (op == OP_JMP) || (op == OP_HLT);
  endfunction

endpackage

// File: rtl/fetch_decode_if.sv
// ---------------------------------------------------------------------------
// fetch_decode_if
// Issue channel between fetch/decode and the execute unit.
//   DEC_VALID  fetch/decode -> execute  decoded instruction valid
//   OP         fetch/decode -> execute  opcode
//   REG_A      fetch/decode -> execute  destination/first register
//   REG_B      fetch/decode -> execute  source register
//   IMM        fetch/decode -> execute  immediate / address
//   EX_READY   execute -> fetch/decode  instruction accepted
//   ZERO_FLAG  execute -> fetch/decode  zero result of last cmp
// Modports: master = fetch/decode side, slave = execute side.
// ---------------------------------------------------------------------------
interface fetch_decode_if;
  logic       DEC_VALID;
  logic [3:0] OP;
  logic [2:0] REG_A;
  logic [2:0] REG_B;
  logic [7:0] IMM;
  logic       EX_READY;
  logic       ZERO_FLAG;

  modport master (
    output DEC_VALID, OP, REG_A, REG_B, IMM,
    input  EX_READY, ZERO_FLAG
  );

  modport slave (
    input  DEC_VALID, OP, REG_A, REG_B, IMM,
    output EX_READY, ZERO_FLAG
  );
endinterface

// File: rtl/insn_field_split.sv
// ---------------------------------------------------------------------------
// insn_field_split
// Combinational instruction splitter: slices an instruction word into its
// fields and flags the locally-resolved control-flow opcodes. Also used by
// the disassembling trace monitor.
//   i_ir      in   15  instruction word
//   o_op      out  4   opcode
//   o_reg_a   out  3   destination/first register
//   o_reg_b   out  3   source register
//   o_imm     out  8   immediate / address
//   o_is_jmp  out  1   opcode is jmp
//   o_is_je   out  1   opcode is je
//   o_is_hlt  out  1   opcode is hlt
// ---------------------------------------------------------------------------
module insn_field_split
  import cpu15_pkg::*;
(
  input  logic [OP_MSB:0] i_ir,
  output logic [3:0]      o_op,
  output logic [2:0]      o_reg_a,
  output logic [2:0]      o_reg_b,
  output logic [7:0]      o_imm,
  output logic            o_is_jmp,
  output logic            o_is_je,
  output logic            o_is_hlt
);

  assign o_op     = i_ir[OP_MSB:OP_LSB];
  assign o_reg_a  = i_ir[RA_MSB:RA_LSB];
  assign o_reg_b  = i_ir[RB_MSB:RB_LSB];
  // IMM overlaps REG_B; the opcode decides which one execute uses.
  assign o_imm    = i_ir[IMM_MSB:IMM_LSB];
  assign o_is_jmp = (o_op == OP_JMP);
  assign o_is_je  = (o_op == OP_JE);
  assign o_is_hlt = (o_op == OP_HLT);

endmodule

// File: rtl/fetch_decode.sv
// ---------------------------------------------------------------------------
// fetch_decode
// Instruction fetch/decode front end of the 15-bit CPU. Drives the program
// address into a registered ROM, latches the returned word into the IR,
// resolves jmp/je/hlt locally and issues every other instruction to the
// execute unit over a valid/ready handshake.
//   CLK_FT    in   1       system clock, rising edge
//   RESET_N   in   1       asynchronous active-low reset
//   P_COUNT   out  PC_W    program address to the ROM (registered PC)
//   PROM_OUT  in   INSN_W  ROM data, registered by the ROM on CLK_FT
//   HALTED    out  1       hlt retired; core stopped
//   ex        master       issue channel (DEC_VALID/OP/REG_A/REG_B/IMM,
//                          EX_READY/ZERO_FLAG)
// ---------------------------------------------------------------------------
module fetch_decode
  import cpu15_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter int              INSN_W   = 15,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              CLK_FT,
  input  logic              RESET_N,
  output logic [PC_W-1:0]   P_COUNT,
  input  logic [INSN_W-1:0] PROM_OUT,
  output logic              HALTED,
  fetch_decode_if.master    ex
);

  fd_state_t         r_state;
  logic [PC_W-1:0]   r_pc;
  logic [INSN_W-1:0] r_ir;
  logic              r_dec_valid;
  logic              r_halted;

  logic [3:0]        w_op;
  logic [2:0]        w_reg_a;
  logic [2:0]        w_reg_b;
  logic [7:0]        w_imm;
  logic              w_is_jmp;
  logic              w_is_je;
  logic              w_is_hlt;
  logic [PC_W-1:0]   w_target;
  logic [PC_W-1:0]   w_pc_inc;

  insn_field_split u_split (
    .i_ir     (r_ir),
    .o_op     (w_op),
    .o_reg_a  (w_reg_a),
    .o_reg_b  (w_reg_b),
    .o_imm    (w_imm),
    .o_is_jmp (w_is_jmp),
    .o_is_je  (w_is_je),
    .o_is_hlt (w_is_hlt)
  );

  // Branch target is IMM resized to the PC width; increment wraps naturally.
  assign w_target = PC_W'(w_imm);
  assign w_pc_inc = r_pc + PC_W'(1);

  always_ff @(posedge CLK_FT or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= S_ADDR;
      r_pc        <= RESET_PC;
      r_ir        <= '0;
      r_dec_valid <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      case (r_state)
        // ROM samples P_COUNT on this edge.
        S_ADDR: r_state <= S_LATCH;

        // DEC_VALID is decided from the incoming word so it is registered
        // in the same edge that loads the IR.
        S_LATCH: begin
          r_ir        <= PROM_OUT;
          r_dec_valid <= !is_ctrl(PROM_OUT[OP_MSB:OP_LSB]);
          r_state     <= S_ISSUE;
        end

        S_ISSUE: begin
          if (w_is_jmp) begin
            r_pc    <= w_target;
            r_state <= S_ADDR;
          end else if (w_is_je) begin
            r_pc    <= ex.ZERO_FLAG ? w_target : w_pc_inc;
            r_state <= S_ADDR;
          end else if (w_is_hlt) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else if (ex.EX_READY) begin
            r_pc        <= w_pc_inc;
            r_dec_valid <= 1'b0;
            r_state     <= S_ADDR;
          end
        end

        // Terminal until reset.
        S_HALT: r_state <= S_HALT;
      endcase
    end
  end

  assign P_COUNT      = r_pc;
  assign HALTED       = r_halted;
  assign ex.DEC_VALID = r_dec_valid;
  assign ex.OP        = w_op;
  assign ex.REG_A     = w_reg_a;
  assign ex.REG_B     = w_reg_b;
  assign ex.IMM       = w_imm;

endmodule

// File: tb/tb_fetch_decode.sv
// ---------------------------------------------------------------------------
// tb_fetch_decode
// Self-checking bench for fetch_decode: directed program walk, halt, PC wrap,
// asynchronous reset during issue, then a randomized program checked against
// an instruction-level reference model.
// ---------------------------------------------------------------------------
module tb_fetch_decode;

  logic        clk;
  logic        rst_n;
  logic [7:0]  p_count;
  logic [14:0] prom_q;
  logic        halted;

  fetch_decode_if ex_if ();

  fetch_decode u_dut (
    .CLK_FT   (clk),
    .RESET_N  (rst_n),
    .P_COUNT  (p_count),
    .PROM_OUT (prom_q),
    .HALTED   (halted),
    .ex       (ex_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered program ROM
  logic [14:0] rom [256];
  always @(posedge clk) prom_q <= rom[p_count];

  int n_checks = 0;
  int n_fail   = 0;
  int pc       = 0;   // model program counter

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ex_if.EX_READY = 1'b0;
    repeat (2) step();
    check_val("rst_valid", ex_if.DEC_VALID, 0);
    check_val("rst_halted", halted, 0);
    check_val("rst_pc", p_count, 0);
    rst_n = 1'b1;
    pc = 0;
  endtask

  // One instruction at the model PC. hold: EX_READY-low cycles (-1 random);
  // zf: ZERO_FLAG for je (-1 random).
  task automatic run_insn(input int hold, input int zf);
    int word, op, ra, rb, imm, h, z;
    word = int'(rom[pc]);
    op   = word / 2048;
    ra   = (word / 256) % 8;
    rb   = (word / 32) % 8;
    imm  = word % 256;

    check_val("pc_fetch", p_count, pc);
    check_val("valid_addr", ex_if.DEC_VALID, 0);
    ex_if.EX_READY = 1'($urandom_range(0, 1));   // must be ignored here
    step();
    check_val("valid_latch", ex_if.DEC_VALID, 0);
    check_val("pc_latch", p_count, pc);
    ex_if.EX_READY = 1'($urandom_range(0, 1));
    step();

    if (op == 12) begin
      check_val("jmp_valid", ex_if.DEC_VALID, 0);
      step();
      $display("insn pc=%02h word=%04h jmp -> %02h", pc, word, imm);
      pc = imm;
    end else if (op == 11) begin
      z = (zf < 0) ? int'($urandom_range(0, 1)) : zf;
      ex_if.ZERO_FLAG = 1'(z);
      check_val("je_valid", ex_if.DEC_VALID, 0);
      step();
      $display("insn pc=%02h word=%04h je zf=%0d -> %02h", pc, word, z, z ? imm : (pc + 1) % 256);
      pc = z ? imm : (pc + 1) % 256;
    end else if (op == 15) begin
      check_val("hlt_valid", ex_if.DEC_VALID, 0);
      step();
      check_val("hlt_halted", halted, 1);
      check_val("hlt_pc", p_count, pc);
      for (int i = 0; i < 20; i++) begin
        ex_if.EX_READY = ~ex_if.EX_READY;
        step();
        check_val("halt_pc_frozen", p_count, pc);
        check_val("halt_valid", ex_if.DEC_VALID, 0);
        check_val("halt_flag", halted, 1);
      end
      $display("insn pc=%02h word=%04h hlt, reset", pc, word);
      do_reset();
    end else begin
      h = (hold < 0) ? int'($urandom_range(0, 3)) : hold;
      check_val("issue_valid", ex_if.DEC_VALID, 1);
      check_val("issue_op", ex_if.OP, op);
      check_val("issue_ra", ex_if.REG_A, ra);
      check_val("issue_rb", ex_if.REG_B, rb);
      check_val("issue_imm", ex_if.IMM, imm);
      ex_if.EX_READY = 1'b0;
      for (int i = 0; i < h; i++) begin
        step();
        check_val("hold_valid", ex_if.DEC_VALID, 1);
        check_val("hold_op", ex_if.OP, op);
        check_val("hold_ra", ex_if.REG_A, ra);
        check_val("hold_rb", ex_if.REG_B, rb);
        check_val("hold_imm", ex_if.IMM, imm);
        check_val("hold_pc", p_count, pc);
      end
      ex_if.EX_READY = 1'b1;
      step();
      check_val("accept_valid", ex_if.DEC_VALID, 0);
      $display("insn pc=%02h word=%04h issue op=%0d ra=%0d rb=%0d imm=%02h hold=%0d", pc, word, op, ra, rb, imm, h);
      pc = (pc + 1) % 256;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ex_if.EX_READY  = 1'b0;
    ex_if.ZERO_FLAG = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 15'($urandom_range(0, 32767));

    // Directed program walk
    rom[8'h00] = 15'b100100000000000;       // ldh R0,0
    rom[8'h01] = {4'hC, 3'd0, 8'h08};       // jmp 0x08
    rom[8'h08] = 15'b000101000100000;       // add R2,R1
    rom[8'h09] = {4'hC, 3'd0, 8'h12};       // jmp 0x12
    rom[8'h12] = {4'hB, 3'd0, 8'h0E};       // je 0x0E
    rom[8'h0E] = {4'hC, 3'd0, 8'h12};       // jmp 0x12
    rom[8'h13] = 15'b110000000001000;       // jmp 0x08
    rom[8'h14] = {4'hF, 11'd0};             // hlt
    do_reset();
    run_insn(0, -1);
    run_insn(-1, -1);
    run_insn(4, -1);
    run_insn(-1, -1);
    run_insn(-1, 1);
    run_insn(-1, -1);
    run_insn(-1, 0);
    run_insn(-1, -1);
    check_val("walk_end_pc", p_count, 8'h08);

    // Halt
    rom[8'h00] = {4'hC, 3'd0, 8'h14};
    do_reset();
    run_insn(-1, -1);
    run_insn(-1, -1);

    // PC wrap 0xFF -> 0x00
    rom[8'h00] = {4'hC, 3'd0, 8'hFF};
    rom[8'hFF] = 15'b000101000100000;
    do_reset();
    run_insn(-1, -1);
    run_insn(-1, -1);
    check_val("wrap_pc", p_count, 0);

    // Asynchronous reset while an instruction is pending issue
    rom[8'h00] = 15'b000101000100000;
    ex_if.EX_READY = 1'b0;
    step();
    step();
    check_val("pre_rst_valid", ex_if.DEC_VALID, 1);
    rst_n = 1'b0;
    #1;
    check_val("async_rst_valid", ex_if.DEC_VALID, 0);
    check_val("async_rst_pc", p_count, 0);
    $display("async reset during issue");
    do_reset();

    // Randomized program (IR = 0 at address 0 issues as mov R0,R0)
    for (int i = 0; i < 256; i++) rom[i] = 15'($urandom_range(0, 32767));
    rom[8'h00] = 15'd0;
    do_reset();
    for (int n = 0; n < 300; n++) run_insn(-1, -1);
    check_val("final_pc", p_count, pc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
